mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL have parameter DEPTH, default 1024, data memory depth in XLEN words; it is a power of two and at least 4.
REQ-003 The block SHALL have parameter LAT, default 0, extra memory wait cycles per load/store (0..7).
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- RegWriteM  in  1  register write enable
- MemWriteM  in  1  store request
- MemReadM  in  1  load request
- ResultSrcM  in  2  writeback mux select, passed through
- Funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  in  5  destination register
- PCPlus4M  in  XLEN  passed through
- WriteDataM  in  XLEN  store data, right-aligned
- ALU_ResultM  in  XLEN  byte address
- StallM  out  1  hold upstream stages; combinational
- RegWriteW  out  1  registered RegWriteM
- ResultSrcW  out  2  registered ResultSrcM
- RD_W  out  5  registered RD_M
- PCPlus4W  out  XLEN  registered PCPlus4M
- ALU_ResultW  out  XLEN  registered ALU_ResultM
- ReadDataW  out  XLEN  registered, extended load data
- MisalignW  out  1  registered misalignment flag

Function
REQ-005 The word index SHALL be ALU_ResultM[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-006 Stores SHALL write only the byte lanes selected by Funct3M and addr[1:0]: SB one lane, SH lanes {addr[1],0}+{0,1}, SW all four lanes; data is replicated from the low byte/half.
REQ-007 Loads SHALL select a byte or half by addr[1:0]: sign-extend for B/H, zero-extend for BU/HU, pass the full word for W; reserved Funct3 encodings SHALL behave as W.
REQ-008 The FSM SHALL have states IDLE and WAIT, and a 3-bit wait counter.
REQ-009 With LAT=0, a load or store SHALL complete in its M cycle, StallM SHALL stay 0, and W outputs SHALL update at the next edge (1-cycle latency).
REQ-010 With LAT>0, an access seen in IDLE SHALL assert StallM, go to WAIT, and load the counter with LAT-1.
REQ-011 In WAIT with a nonzero counter, StallM SHALL be 1 and the counter SHALL decrement each cycle.
REQ-012 In WAIT with a zero counter, StallM SHALL be 0, the access SHALL complete, and the state SHALL return to IDLE; total M-to-W latency is LAT+1 cycles.
REQ-013 Upstream SHALL hold all M inputs stable while StallM=1; the block does not sample them mid-access.
REQ-014 A store SHALL write memory exactly once, at the completing edge; load data SHALL be sampled at that same edge.
REQ-015 While StallM=1, the W register SHALL capture a bubble: RegWriteW=0, ResultSrcW=0, RD_W=0, MisalignW=0, data fields 0.
REQ-016 MemReadM and MemWriteM both high SHALL be treated as a store, with ReadDataW loaded from the pre-write word.
REQ-017 Non-memory ops SHALL never stall; in IDLE they pass to W in one cycle, with ReadDataW equal to the extended read of the addressed word.
REQ-018 An op back-to-back after a completed access SHALL start in IDLE with no idle gap.

Reset
REQ-019 rst low SHALL asynchronously clear all W outputs to 0, force the FSM to IDLE and the counter to 0, and deassert StallM.
REQ-020 A reset during WAIT SHALL abort the access without a memory write.
REQ-021 Memory contents SHALL NOT be cleared by rst; they are undefined after power-up.

Configuration
REQ-022 With macro LSU_MISALIGN_CHECK_EN defined, an H access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL:
- set MisalignW=1 and force RegWriteW=0
- suppress the store write
- incur no wait cycles
REQ-023 Without LSU_MISALIGN_CHECK_EN, MisalignW SHALL be tied to 0 and addr bits below the access size SHALL be treated as 0 (forced alignment).

Verification
REQ-024 The bench SHALL cover: LAT=0, SW 0xDEADBEEF @0x10, then LW @0x10 -> ReadDataW=0xDEADBEEF one cycle after the load, StallM never 1.
REQ-025 The bench SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-026 The bench SHALL cover: LAT=3, LW -> StallM high for exactly 3 cycles, three bubbles on W (RegWriteW=0), data valid 4 cycles after issue.
REQ-027 The bench SHALL cover: LAT=3, rst pulsed low in the 2nd stall cycle of SW 0x1234 @0x20 -> StallM=0 and outputs 0 immediately; a later LW @0x20 returns the old contents.
REQ-028 The bench SHALL cover, with LSU_MISALIGN_CHECK_EN: SH @0x21 -> MisalignW=1, RegWriteW=0, memory unchanged; without the macro, the same SH writes lanes 0-1 of word 0x20.
REQ-029 The bench SHALL cover: DEPTH=1024, SW 0x55 @0x1000 then LW @0x0 -> 0x00000055 (address wrap).

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// M-stage request bundle and W-stage result bundle of the memory-stage load/store unit.
// The pipeline side uses the master modport; the LSU uses the slave modport.
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic            RegWriteM;
    logic            MemWriteM;
    logic            MemReadM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] ALU_ResultM;

    logic            StallM;
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [4:0]      RD_W;
    logic [XLEN-1:0] PCPlus4W;
    logic [XLEN-1:0] ALU_ResultW;
    logic [XLEN-1:0] ReadDataW;
    logic            MisalignW;

    modport master (
        output RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM,
        input  StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, MisalignW
    );

    modport slave (
        input  RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM,
        output StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
               ReadDataW, MisalignW
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: byte-lane data memory, LAT wait states per access and an
// M->W pipeline register. Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses.
module mem_stage_lsu #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int LAT   = 0
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic            misalign;
    } wb_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    wb_t             r_wb;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_is_b, w_is_h, w_unsigned;
    logic            w_mem_op, w_misalign, w_access, w_done, w_we;
    logic [1:0]      w_off;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_rword, w_rshift, w_load;

    // Reserved Funct3 encodings fall through to word accesses.
    assign w_is_b     = (bus.Funct3M[1:0] == 2'b00);
    assign w_is_h     = (bus.Funct3M[1:0] == 2'b01);
    assign w_unsigned = bus.Funct3M[2];
    assign w_mem_op   = bus.MemReadM | bus.MemWriteM;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = w_mem_op & ((w_is_h & bus.ALU_ResultM[0]) |
                        (~w_is_b & ~w_is_h & (bus.ALU_ResultM[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_access = w_mem_op & ~w_misalign;
    assign w_off    = w_is_b ? bus.ALU_ResultM[1:0] :
                      w_is_h ? {bus.ALU_ResultM[1], 1'b0} : 2'b00;
    assign w_idx    = bus.ALU_ResultM[AW+1:2];
    assign w_be     = w_is_b ? (4'b0001 << w_off) :
                      w_is_h ? (4'b0011 << w_off) : 4'b1111;
    assign w_wdata  = w_is_b ? {4{bus.WriteDataM[7:0]}} :
                      w_is_h ? {2{bus.WriteDataM[15:0]}} : bus.WriteDataM;
    assign w_rword  = r_mem[w_idx];
    assign w_rshift = w_rword >> {w_off, 3'b000};

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_load = w_rword;
        if (w_is_b)
            w_load = {{24{~w_unsigned & w_rshift[7]}}, w_rshift[7:0]};
        else if (w_is_h)
            w_load = {{16{~w_unsigned & w_rshift[15]}}, w_rshift[15:0]};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (w_access && (LAT > 0)) begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_LOAD;
            end
            WAIT: if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
                  else               w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // w_done marks the completing cycle; the memory write and W capture both key off it.
    always_comb begin
        w_done = 1'b1;
        case (r_state)
            IDLE:    w_done = !(w_access && (LAT > 0));
            WAIT:    w_done = (r_cnt == 3'd0);
            default: w_done = 1'b1;
        endcase
    end

    assign bus.StallM = rst & ~w_done;
    assign w_we       = bus.MemWriteM & ~w_misalign & w_done;

    // NOTE: the data array deliberately has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb <= '0;
        end else if (!w_done) begin
            r_wb <= '0;
        end else begin
            r_wb <= '{reg_write:  bus.RegWriteM & ~w_misalign,
                      result_src: bus.ResultSrcM,
                      rd:         bus.RD_M,
                      pc_plus4:   bus.PCPlus4M,
                      alu_result: bus.ALU_ResultM,
                      read_data:  w_load,
                      misalign:   w_misalign};
        end
    end

    assign bus.RegWriteW   = r_wb.reg_write;
    assign bus.ResultSrcW  = r_wb.result_src;
    assign bus.RD_W        = r_wb.rd;
    assign bus.PCPlus4W    = r_wb.pc_plus4;
    assign bus.ALU_ResultW = r_wb.alu_result;
    assign bus.ReadDataW   = r_wb.read_data;
    assign bus.MisalignW   = r_wb.misalign;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu: a LAT=0 and a LAT=3 instance, each compared
// every cycle against a byte-addressed memory model with transaction-level latency.
module tb_mem_stage_lsu;
    localparam int DEPTH  = 1024;
    localparam int ABYTES = 4 * DEPTH;

    typedef struct packed {
        logic        rw, mw, mr;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc, wd, addr;
    } op_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc, alu, rdata;
        logic        mis;
    } wout_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(32)) bus0 ();
    mem_stage_lsu_if #(.XLEN(32)) bus3 ();

    mem_stage_lsu #(.XLEN(32), .DEPTH(DEPTH), .LAT(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
    mem_stage_lsu #(.XLEN(32), .DEPTH(DEPTH), .LAT(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

    int         lat_of [2] = '{0, 3};
    logic [7:0] mdl_mem [2][ABYTES];   // starts X: unwritten bytes are unknown
    int         n_checks = 0;
    int         n_errors = 0;
    int         act = -1;
    logic       exp_stall;
    wout_t      exp_w;
    wout_t      pend_w [2];
    wout_t      cmp_w;
    int         stall_cnt [2] = '{0, 0};
    int         bub3 = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input int d, input op_t op);
        if (d == 0) begin
            bus0.RegWriteM = op.rw;  bus0.MemWriteM = op.mw;  bus0.MemReadM = op.mr;
            bus0.ResultSrcM = op.rs; bus0.Funct3M = op.f3;    bus0.RD_M = op.rd;
            bus0.PCPlus4M = op.pc;   bus0.WriteDataM = op.wd; bus0.ALU_ResultM = op.addr;
        end else begin
            bus3.RegWriteM = op.rw;  bus3.MemWriteM = op.mw;  bus3.MemReadM = op.mr;
            bus3.ResultSrcM = op.rs; bus3.Funct3M = op.f3;    bus3.RD_M = op.rd;
            bus3.PCPlus4M = op.pc;   bus3.WriteDataM = op.wd; bus3.ALU_ResultM = op.addr;
        end
    endtask

    function automatic wout_t get_w(input int d);
        wout_t w;
        if (d == 0) begin
            w.rw = bus0.RegWriteW; w.rs = bus0.ResultSrcW; w.rd = bus0.RD_W; w.pc = bus0.PCPlus4W;
            w.alu = bus0.ALU_ResultW; w.rdata = bus0.ReadDataW; w.mis = bus0.MisalignW;
        end else begin
            w.rw = bus3.RegWriteW; w.rs = bus3.ResultSrcW; w.rd = bus3.RD_W; w.pc = bus3.PCPlus4W;
            w.alu = bus3.ALU_ResultW; w.rdata = bus3.ReadDataW; w.mis = bus3.MisalignW;
        end
        return w;
    endfunction

    function automatic logic get_stall(input int d);
        return (d == 0) ? bus0.StallM : bus3.StallM;
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic is_mis(input op_t op);
`ifdef LSU_MISALIGN_CHECK_EN
        return (op.mr || op.mw) && ((int'(op.addr[1:0]) % acc_size(op.f3)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Result of an op at its completing edge; applies a store to the model memory.
    function automatic wout_t model(input int d, input op_t op);
        wout_t       w;
        int          a, size, base;
        logic        sgn, mis;
        logic [31:0] v;
        a    = int'(op.addr % 32'(ABYTES));
        size = acc_size(op.f3);
        sgn  = (op.f3 == 3'b000) || (op.f3 == 3'b001);
        mis  = is_mis(op);
        base = a - (a % size);
        v    = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mdl_mem[d][base + i];
        if (size == 1)      v = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
        else if (size == 2) v = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
        if (op.mw && !mis)
            for (int i = 0; i < size; i++) mdl_mem[d][base + i] = op.wd[8*i +: 8];
        w.rw = op.rw && !mis; w.rs = op.rs; w.rd = op.rd; w.pc = op.pc;
        w.alu = op.addr; w.rdata = v; w.mis = mis;
        return w;
    endfunction

    function automatic op_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
        op_t o;
        o.rw = mr; o.mw = mw; o.mr = mr; o.rs = mr ? 2'b01 : 2'b00; o.f3 = f3;
        o.rd = 5'd10; o.pc = 32'h400 + addr; o.wd = wd; o.addr = addr;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.rw = 1'($urandom_range(0, 1));
        o.mw = ($urandom_range(0, 3) == 0);
        o.mr = ($urandom_range(0, 2) == 0);
        o.rs = 2'($urandom_range(0, 3));
        o.f3 = 3'($urandom_range(0, 7));
        o.rd = 5'($urandom_range(0, 31));
        o.pc = $urandom;
        o.wd = $urandom;
        o.addr = $urandom & 32'hFFFF_F03F;   // words 0..15, upper bits exercise the wrap
        return o;
    endfunction

    // Presents op to DUT d until it completes; entered and left at posedge+2.
    task automatic run_op(input int d, input op_t op, output wout_t res);
        int wl;
        wl  = ((op.mr || op.mw) && !is_mis(op)) ? lat_of[d] : 0;
        act = d;
        drive(d, op);
        for (int k = 0; k <= wl; k++) begin
            exp_stall = (k < wl);
            exp_w     = pend_w[d];
            pend_w[d] = (k < wl) ? wout_t'('0) : model(d, op);
            @(posedge clk);
            #2;
        end
        res = pend_w[d];
    endtask

    always @(negedge clk) begin
        if (bus0.StallM) stall_cnt[0]++;
        if (bus3.StallM) stall_cnt[1]++;
        if (!bus3.RegWriteW) bub3++;
        if (act >= 0) begin
            cmp_w = get_w(act);
            check("stall", get_stall(act), exp_stall);
            check("regwrite_w", cmp_w.rw, exp_w.rw);
            check("resultsrc_w", cmp_w.rs, exp_w.rs);
            check("rd_w", cmp_w.rd, exp_w.rd);
            check("pcplus4_w", cmp_w.pc, exp_w.pc);
            check("aluresult_w", cmp_w.alu, exp_w.alu);
            check("misalign_w", cmp_w.mis, exp_w.mis);
            if (!$isunknown(exp_w.rdata) && !exp_w.mis)
                check("readdata_w", cmp_w.rdata, exp_w.rdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wout_t r;
        op_t   op;
        int    s0, b0;
        rst0 = 1'b0;
        rst3 = 1'b0;
        drive(0, '0);
        drive(1, '0);
        pend_w[0] = '0;
        pend_w[1] = '0;
        #8;
        check("rst_stall0", bus0.StallM, 1'b0);
        check("rst_stall3", bus3.StallM, 1'b0);
        check("rst_w0", get_w(0), '0);
        check("rst_w3", get_w(1), '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst0 = 1'b1;
        rst3 = 1'b1;

        // LAT=0 instance
        for (int w = 0; w < 16; w++) run_op(0, mk(0, 1, 3'b010, 32'(4 * w), 32'hC0DE_0000 | 32'(w)), r);
        run_op(0, mk(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF), r);
        run_op(0, mk(1, 0, 3'b010, 32'h10, 32'h0), r);
        check("lw_10_model", r.rdata, 32'hDEAD_BEEF);
        check("lw_10_dut", bus0.ReadDataW, 32'hDEAD_BEEF);
        run_op(0, mk(0, 1, 3'b000, 32'h13, 32'h80), r);
        run_op(0, mk(1, 0, 3'b000, 32'h13, 32'h0), r);
        check("lb_13_model", r.rdata, 32'hFFFF_FF80);
        check("lb_13_dut", bus0.ReadDataW, 32'hFFFF_FF80);
        run_op(0, mk(1, 0, 3'b100, 32'h13, 32'h0), r);
        check("lbu_13_dut", bus0.ReadDataW, 32'h0000_0080);
        run_op(0, mk(1, 0, 3'b010, 32'h10, 32'h0), r);
        check("lw_10_after_sb_dut", bus0.ReadDataW, 32'h80AD_BEEF);

        op = mk(0, 1, 3'b001, 32'h21, 32'h0000_CAFE);
        op.rw = 1'b1;
        run_op(0, op, r);
`ifdef LSU_MISALIGN_CHECK_EN
        check("sh_21_misalign", bus0.MisalignW, 1'b1);
        check("sh_21_regwrite", bus0.RegWriteW, 1'b0);
        run_op(0, mk(1, 0, 3'b010, 32'h20, 32'h0), r);
        check("lw_20_after_sh_dut", bus0.ReadDataW, 32'hC0DE_0008);
`else
        check("sh_21_misalign", bus0.MisalignW, 1'b0);
        check("sh_21_regwrite", bus0.RegWriteW, 1'b1);
        run_op(0, mk(1, 0, 3'b010, 32'h20, 32'h0), r);
        check("lw_20_after_sh_dut", bus0.ReadDataW, 32'hC0DE_CAFE);
`endif
        run_op(0, mk(0, 1, 3'b010, 32'h1000, 32'h55), r);
        run_op(0, mk(1, 0, 3'b010, 32'h0, 32'h0), r);
        check("lw_wrap_dut", bus0.ReadDataW, 32'h0000_0055);

        for (int n = 0; n < 400; n++) run_op(0, rnd_op(), r);
        run_op(0, '0, r);
        act = -1;
        drive(0, '0);

        // LAT=3 instance; it has been capturing all-zero ops since reset
        pend_w[1] = model(1, '0);
        for (int w = 0; w < 16; w++) run_op(1, mk(0, 1, 3'b010, 32'(4 * w), 32'hC0DE_0000 | 32'(w)), r);
        op = mk(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        op.rw = 1'b1;
        run_op(1, op, r);
        s0 = stall_cnt[1];
        b0 = bub3;
        run_op(1, mk(1, 0, 3'b010, 32'h10, 32'h0), r);
        check("lat3_stall_cycles", stall_cnt[1] - s0, 3);
        check("lat3_bubbles", bub3 - b0, 3);
        check("lat3_lw_dut", bus3.ReadDataW, 32'hDEAD_BEEF);
        check("lat3_lw_regwrite", bus3.RegWriteW, 1'b1);

        act = -1;
        drive(1, mk(0, 1, 3'b010, 32'h20, 32'h1234));
        @(posedge clk);
        #3;
        check("pre_rst_stall", bus3.StallM, 1'b1);
        rst3 = 1'b0;
        #1;
        check("mid_rst_stall", bus3.StallM, 1'b0);
        check("mid_rst_w", get_w(1), '0);
        drive(1, '0);
        #2;
        rst3 = 1'b1;
        pend_w[1] = model(1, '0);
        @(posedge clk);
        #2;
        run_op(1, mk(1, 0, 3'b010, 32'h20, 32'h0), r);
        check("lw_20_after_abort_dut", bus3.ReadDataW, 32'hC0DE_0008);

        for (int n = 0; n < 200; n++) run_op(1, rnd_op(), r);
        run_op(1, '0, r);
        act = -1;

        check("lat0_never_stalled", stall_cnt[0], 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
